// File: rtl/fp_entry_ctrl_pkg.sv
// Shared types and helpers for the front-panel entry controller.
// FP_AUTOINC_EN adds the INC state used to step the address after a write.
package fp_pkg;

    localparam int NIBBLE_W = 4;

`ifdef FP_AUTOINC_EN
    typedef enum logic [1:0] {IDLE, WR, INC, LD} fp_state_e;
`else
    typedef enum logic [1:0] {IDLE, WR, LD} fp_state_e;
`endif

    // Width needed to count 0..DW/4 typed nibbles.
    function automatic int digits_w(input int dw);
        return $clog2(dw / NIBBLE_W + 1);
    endfunction

endpackage

// File: rtl/fp_entry_ctrl_if.sv
// Panel event / core bus bundle between the front panel and fp_entry_ctrl.
interface fp_entry_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    import fp_pkg::*;

    localparam int DGW = digits_w(DW);

    logic                prog;
    logic                clear;
    logic [AW-1:0]       adr_preset;
    logic                key_valid;
    logic [NIBBLE_W-1:0] key_code;
    logic                key_bs;
    logic                adr_inc;
    logic                adr_dec;
    logic                write_req;
    logic [DW-1:0]       mem_rdata;
    logic [AW-1:0]       fp_adr;
    logic [DW-1:0]       fp_data;
    logic                fp_write;
    logic                busy;
    logic [DGW-1:0]      digits;

    modport slave (
        input  prog, clear, adr_preset, key_valid, key_code, key_bs,
               adr_inc, adr_dec, write_req, mem_rdata,
        output fp_adr, fp_data, fp_write, busy, digits
    );

    modport master (
        output prog, clear, adr_preset, key_valid, key_code, key_bs,
               adr_inc, adr_dec, write_req, mem_rdata,
        input  fp_adr, fp_data, fp_write, busy, digits
    );

endinterface

// File: rtl/fp_entry_ctrl_delay_cnt.sv
// 4-bit loadable down-counter; holds at zero and flags it.
module fp_delay_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] value,
    output logic       zero
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = value;
        else if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 4'd0;
        else          cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/fp_entry_ctrl.sv
// Front-panel program-entry controller: address/data entry, timed write, readback reload.
// Define FP_AUTOINC_EN to step to the next address after each completed write.
module fp_entry_ctrl
    import fp_pkg::*;
#(
    parameter int            AW        = 4,
    parameter int            DW        = 8,
    parameter int            WR_CYCLES = 2,
    parameter int            RD_LAT    = 1,
    parameter logic [AW-1:0] ADR_RESET = '0
) (
    input logic            clk,
    input logic            reset_n,
    fp_entry_ctrl_if.slave bus
);

    localparam int             DGW    = digits_w(DW);
    localparam logic [DGW-1:0] DMAX   = DGW'(DW / NIBBLE_W);
    // Counter holds WR_CYCLES-1 so WR lasts exactly WR_CYCLES cycles.
    localparam logic [3:0]     WR_VAL = 4'(WR_CYCLES - 1);
    localparam logic [3:0]     RD_VAL = 4'(RD_LAT);

    fp_state_e      state_q, state_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]  data_q, data_d;
    logic [DGW-1:0] digits_q, digits_d;
    logic           write_q, write_d;
    logic           cnt_load;
    logic [3:0]     cnt_val;
    logic           cnt_zero;

    fp_delay_cnt u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .value   (cnt_val),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        data_d   = data_q;
        digits_d = digits_q;
        write_d  = write_q;
        cnt_load = 1'b0;
        cnt_val  = 4'd0;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    adr_d    = bus.adr_preset;
                    state_d  = LD;
                    cnt_load = 1'b1;
                    cnt_val  = RD_VAL;
                end else if (bus.write_req && bus.prog) begin
                    state_d  = WR;
                    write_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = WR_VAL;
                end else if (bus.adr_inc) begin
                    adr_d    = adr_q + AW'(1);
                    state_d  = LD;
                    cnt_load = 1'b1;
                    cnt_val  = RD_VAL;
                end else if (bus.adr_dec) begin
                    adr_d    = adr_q - AW'(1);
                    state_d  = LD;
                    cnt_load = 1'b1;
                    cnt_val  = RD_VAL;
                end else if (bus.key_bs && bus.prog) begin
                    data_d   = data_q >> NIBBLE_W;
                    digits_d = (digits_q == '0) ? digits_q : digits_q - DGW'(1);
                end else if (bus.key_valid && bus.prog) begin
                    data_d   = (data_q << NIBBLE_W) | DW'(bus.key_code);
                    digits_d = (digits_q == DMAX) ? digits_q : digits_q + DGW'(1);
                end
            end
            WR: begin
                if (cnt_zero) begin
                    write_d  = 1'b0;
                    digits_d = '0;
`ifdef FP_AUTOINC_EN
                    state_d  = INC;
`else
                    state_d  = IDLE;
`endif
                end
            end
`ifdef FP_AUTOINC_EN
            INC: begin
                adr_d    = adr_q + AW'(1);
                state_d  = LD;
                cnt_load = 1'b1;
                cnt_val  = RD_VAL;
            end
`endif
            LD: begin
                if (cnt_zero) begin
                    data_d   = bus.mem_rdata;
                    digits_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // fp_write is a flop so reset clears it asynchronously mid-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            adr_q    <= ADR_RESET;
            data_q   <= '0;
            digits_q <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            digits_q <= digits_d;
            write_q  <= write_d;
        end
    end

    assign bus.fp_adr   = adr_q;
    assign bus.fp_data  = data_q;
    assign bus.fp_write = write_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.digits   = digits_q;

endmodule

// File: tb/tb_fp_entry_ctrl.sv
// Directed vector bench for fp_entry_ctrl (default 4/8 instance plus an AW=8/DW=16 instance).
module tb_fp_entry_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fp_entry_ctrl_if #(.AW(4), .DW(8))  a_if ();
    fp_entry_ctrl_if #(.AW(8), .DW(16)) b_if ();

    fp_entry_ctrl #(.AW(4), .DW(8), .WR_CYCLES(2), .RD_LAT(1), .ADR_RESET(4'h0)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
    fp_entry_ctrl #(.AW(8), .DW(16), .WR_CYCLES(2), .RD_LAT(1), .ADR_RESET(8'h00)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if.slave));

    // Memory model: mem[0]=0x5C, mem[i]=0x30+i otherwise; written on fp_write.
    logic [7:0] mem [16];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 8'h5C : 8'(8'h30 + i);
        end else if (a_if.fp_write) begin
            mem[a_if.fp_adr] <= a_if.fp_data;
        end
    end
    assign a_if.mem_rdata = mem[a_if.fp_adr];
    assign b_if.mem_rdata = 16'h0000;

    typedef struct {
        logic       prog, clr;
        logic [3:0] pre;
        logic       kv;
        logic [3:0] kc;
        logic       bs, inc, dec, wr;
        logic [3:0] e_adr;
        logic [7:0] e_data;
        logic [1:0] e_dig;
        logic       e_busy, e_we;
    } vec_t;

    vec_t v[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic prog, clr, input logic [3:0] pre, input logic kv,
                                input logic [3:0] kc, input logic bs, inc, dec, wr,
                                input logic [3:0] e_adr, input logic [7:0] e_data,
                                input logic [1:0] e_dig, input logic e_busy, e_we);
        vec_t r;
        r.prog = prog; r.clr = clr; r.pre = pre; r.kv = kv; r.kc = kc; r.bs = bs;
        r.inc = inc; r.dec = dec; r.wr = wr; r.e_adr = e_adr; r.e_data = e_data;
        r.e_dig = e_dig; r.e_busy = e_busy; r.e_we = e_we;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t x);
        a_if.prog = x.prog; a_if.clear = x.clr; a_if.adr_preset = x.pre;
        a_if.key_valid = x.kv; a_if.key_code = x.kc; a_if.key_bs = x.bs;
        a_if.adr_inc = x.inc; a_if.adr_dec = x.dec; a_if.write_req = x.wr;
    endtask

    task automatic b_key(input logic [3:0] k);
        b_if.key_valid = 1'b1; b_if.key_code = k;
        @(posedge clk); #1;
        b_if.key_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] adr_a;
        logic [7:0] dat_a;
        vec_t idle;
        idle = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        drive_a(idle);
        a_if.prog = 1'b0;
        b_if.prog = 1'b1; b_if.clear = 0; b_if.adr_preset = 8'h00; b_if.key_valid = 0;
        b_if.key_code = 0; b_if.key_bs = 0; b_if.adr_inc = 0; b_if.adr_dec = 0; b_if.write_req = 0;

        //       prog clr pre kv kc bs inc dec wr | adr data dig busy we
        v.push_back(mk(1,0,0,1,4'h3,0,0,0,0, 4'h0,8'h03,1,0,0));
        v.push_back(mk(1,0,0,1,4'hA,0,0,0,0, 4'h0,8'h3A,2,0,0));
        v.push_back(mk(1,0,0,1,4'h7,0,0,0,0, 4'h0,8'hA7,2,0,0));
        v.push_back(mk(1,0,0,0,4'h0,1,0,0,0, 4'h0,8'h0A,1,0,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h0,8'h0A,1,0,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,1,0, 4'hF,8'h0A,1,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'hF,8'h0A,1,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'hF,8'h3F,0,0,0));
        v.push_back(mk(1,0,0,0,4'h0,0,1,0,0, 4'h0,8'h3F,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h0,8'h3F,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h0,8'h5C,0,0,0));
        v.push_back(mk(1,1,3,0,4'h0,0,0,0,0, 4'h3,8'h5C,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h3,8'h5C,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h3,8'h33,0,0,0));
        v.push_back(mk(1,0,0,1,4'h4,0,0,0,0, 4'h3,8'h34,1,0,0));
        v.push_back(mk(1,0,0,1,4'h2,0,0,0,0, 4'h3,8'h42,2,0,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,1, 4'h3,8'h42,2,1,1));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h3,8'h42,2,1,1));
`ifdef FP_AUTOINC_EN
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h3,8'h42,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h4,8'h42,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h4,8'h42,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h4,8'h34,0,0,0));
        adr_a = 4'h5; dat_a = 8'h35;
`else
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h3,8'h42,0,0,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, 4'h3,8'h42,0,0,0));
        adr_a = 4'h4; dat_a = 8'h34;
`endif
        v.push_back(mk(1,0,0,1,4'h5,0,1,0,0, adr_a,v[v.size()-1].e_data,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,1,0, adr_a,v[v.size()-1].e_data,0,1,0));
        v.push_back(mk(1,0,0,0,4'h0,0,0,0,0, adr_a,dat_a,0,0,0));
        v.push_back(mk(0,0,0,1,4'h9,0,0,0,0, adr_a,dat_a,0,0,0));
        v.push_back(mk(0,0,0,0,4'h0,0,0,0,1, adr_a,dat_a,0,0,0));
        v.push_back(mk(0,1,9,0,4'h0,0,0,0,0, 4'h9,dat_a,0,1,0));
        v.push_back(mk(0,0,0,0,4'h0,0,0,0,0, 4'h9,dat_a,0,1,0));
        v.push_back(mk(0,0,0,0,4'h0,0,0,0,0, 4'h9,8'h39,0,0,0));
        v.push_back(mk(1,0,0,0,4'h0,1,0,0,0, 4'h9,8'h03,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst adr",   32'(a_if.fp_adr),   32'h0);
        chk("rst data",  32'(a_if.fp_data),  32'h0);
        chk("rst we",    32'(a_if.fp_write), 32'h0);
        chk("rst busy",  32'(a_if.busy),     32'h0);
        chk("rst digits",32'(a_if.digits),   32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            drive_a(v[i]);
            @(posedge clk); #1;
            chk($sformatf("v%0d adr", i),    32'(a_if.fp_adr),   32'(v[i].e_adr));
            chk($sformatf("v%0d data", i),   32'(a_if.fp_data),  32'(v[i].e_data));
            chk($sformatf("v%0d digits", i), 32'(a_if.digits),   32'(v[i].e_dig));
            chk($sformatf("v%0d busy", i),   32'(a_if.busy),     32'(v[i].e_busy));
            chk($sformatf("v%0d we", i),     32'(a_if.fp_write), 32'(v[i].e_we));
        end
        drive_a(idle);
        chk("mem3 written", 32'(mem[3]), 32'h42);

        // Wide instance: four keys fill 16 bits, fifth saturates digits.
        b_key(4'h1); b_key(4'h2); b_key(4'h3); b_key(4'h4);
        chk("b data 1234",  32'(b_if.fp_data), 32'h1234);
        chk("b digits 4",   32'(b_if.digits),  32'd4);
        b_key(4'h5);
        chk("b data 2345",  32'(b_if.fp_data), 32'h2345);
        chk("b digits sat", 32'(b_if.digits),  32'd4);

        // Reset in the middle of a write clears the strobe without a clock edge.
        a_if.prog = 1'b1; a_if.write_req = 1'b1;
        @(posedge clk); #1;
        a_if.write_req = 1'b0;
        chk("midwr we", 32'(a_if.fp_write), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async we",     32'(a_if.fp_write), 32'h0);
        chk("async adr",    32'(a_if.fp_adr),   32'h0);
        chk("async data",   32'(a_if.fp_data),  32'h0);
        chk("async digits", 32'(a_if.digits),   32'h0);
        chk("async busy",   32'(a_if.busy),     32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst busy", 32'(a_if.busy),    32'h0);
        chk("post rst we",   32'(a_if.fp_write),32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_entry_ctrl.md
Name: fp_entry_ctrl

Overview:
Parametrised front-panel program-entry controller, the successor to the fixed 4-bit-address / 8-bit-data hex entry logic in the board top.
- Accepts pre-debounced single-cycle events: hex key, backspace, address up/down, write, clear.
- Maintains the panel address and the data entry register.
- Issues a timed memory write strobe to the core.
- Reloads the data register from memory readback after every address change.

Parameters:
AW, 4, address width in bits (1..16)
DW, 8, data width in bits; multiple of 4, 4..32
WR_CYCLES, 2, cycles fp_write is held high (1..15)
RD_LAT, 1, cycles from fp_adr change to valid mem_rdata (0..15)
ADR_RESET, 0, fp_adr value on reset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
prog  in  1  program mode; 0 = key, backspace and write events ignored
clear  in  1  pulse: load fp_adr from adr_preset, then reload data
adr_preset  in  AW  address loaded on clear
key_valid  in  1  pulse: hex key pressed
key_code  in  4  hex digit, qualified by key_valid
key_bs  in  1  pulse: backspace
adr_inc  in  1  pulse: address +1
adr_dec  in  1  pulse: address -1
write_req  in  1  pulse: write fp_data to fp_adr (honoured only if prog=1)
mem_rdata  in  DW  memory read data at fp_adr
fp_adr  out  AW  panel address to core
fp_data  out  DW  entry register to core
fp_write  out  1  write strobe to core
busy  out  1  high in any state other than IDLE
digits  out  $clog2(DW/4+1)  count of nibbles typed since last load

Behaviour:
- Reset (async, reset_n=0):
  - fp_adr=ADR_RESET, fp_data=0, fp_write=0, digits=0, busy=0.
  - State goes to IDLE. No automatic reload.
- States: IDLE, WR, INC, LD. A shared down-counter times WR and LD.
- IDLE acts on at most one event per cycle. Priority: clear > write_req > adr_inc > adr_dec > key_bs > key_valid. Lower-priority events in the same cycle are dropped.
  - clear: fp_adr<=adr_preset; go to LD. Honoured regardless of prog.
  - write_req with prog=1: go to WR. fp_write=1 from the next cycle for exactly WR_CYCLES cycles. fp_adr and fp_data are frozen throughout.
  - adr_inc: fp_adr<=fp_adr+1, modulo 2^AW (max wraps to 0); go to LD.
  - adr_dec: fp_adr<=fp_adr-1 (0 wraps to max); go to LD.
  - key_valid with prog=1:
    - fp_data<={fp_data[DW-5:0],key_code}.
    - digits<=min(digits+1, DW/4); saturates at DW/4.
  - key_bs with prog=1: fp_data<=fp_data>>4; digits<=max(digits-1, 0).
- WR: after WR_CYCLES cycles, fp_write<=0, digits<=0, then go to INC (FP_AUTOINC_EN defined) or IDLE (undefined).
- INC: one cycle; fp_adr<=fp_adr+1 with wrap; go to LD.
- LD: wait RD_LAT cycles; then, on the next cycle, fp_data<=mem_rdata and digits<=0; return to IDLE.
  - With RD_LAT=0 the capture occurs on the cycle after entering LD.
- Busy handling: all events (including clear) arriving while busy=1 are dropped, not queued.
- fp_write is never high outside WR.
- Reset asserted mid-WR deasserts fp_write immediately (asynchronously).
- Write with digits=0 is legal; it writes the current fp_data.

Optional Feature:
FP_AUTOINC_EN
- Defined: a completed write advances through INC then LD, so the panel steps to the next address showing its contents. A write at address 2^AW-1 wraps to 0.
- Undefined: the INC state is not compiled. After WR the controller returns to IDLE with fp_adr and fp_data unchanged and digits=0.

Decomposition:
- Package fp_pkg holds:
  - the state enum (IDLE, WR, INC, LD);
  - NIBBLE_W=4;
  - a function returning the digits width for a given DW.
- One sub-module, fp_delay_cnt: a 4-bit loadable down-counter with load, value and zero flag. The FSM uses it for both WR_CYCLES and RD_LAT timing.

Test Plan:
- Defaults, prog=1, keys 3 then A then 7 → fp_data=0xA7, digits=2 (saturated); key_bs → fp_data=0x0A, digits=1.
- fp_adr=0xF, adr_inc → fp_adr=0x0; with mem_rdata=0x5C, fp_data=0x5C and digits=0 two cycles later (RD_LAT=1); busy high throughout.
- prog=1, fp_adr=3, fp_data=0x42, write_req → fp_write high for exactly 2 cycles at adr 3 with data 0x42.
  - FP_AUTOINC_EN defined: fp_adr=4 and data reloaded afterwards.
  - Undefined: fp_adr stays 3.
- adr_inc and key_valid in the same IDLE cycle → address increments, key dropped; adr_dec pulse during LD → ignored, fp_adr unchanged.
- prog=0, key_valid and write_req → fp_data unchanged, fp_write never asserted; clear with adr_preset=0x9 → fp_adr=0x9, reload occurs.
- reset_n low during WR → fp_write=0 in the same cycle, all outputs at reset values; AW=8, DW=16 instance: four keys 1,2,3,4 → fp_data=0x1234, digits=4.
